hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline interlock controller for the 5-stage core, sitting beside the ID stage. It tracks the destination registers of instructions in flight in EXE, MEM and WB with a 3-entry scoreboard, and detects read-after-write hazards for the instruction currently in ID. It freezes PC and IF/ID, injects bubbles into ID/EX, and gates the IF flush that accompanies a taken branch or jump. It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the `stall_count` and `flush_count` counters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- src1  in  5  first source register of the ID instruction.
- src2  in  5  second source register (store data or bne operand included).
- uses_src2  in  1  ID instruction reads src2 (R-type, store, branch).
- id_dest  in  5  destination register of the ID instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_r_en  in  1  ID instruction is a load.
- br_taken  in  1  branch/jump resolved taken in ID.
- freeze  out  1  hold PC and IF/ID register.
- bubble  out  1  force zero control (WB/MEM enables, EXE_CMD) into ID/EX.
- if_flush  out  1  clear IF/ID on the next edge.
- stall_count  out  CNT_W  total cycles with `freeze` = 1, saturating.
- flush_count  out  CNT_W  total cycles with `if_flush` = 1, saturating.

## Operation
- Scoreboard: three entries, EXE, MEM and WB. Each entry is {v, dest[4:0], ld}.
- Scoreboard update on every edge (back end never stalls):
  - WB ← MEM.
  - MEM ← EXE.
  - EXE ← {1, id_dest, id_mem_r_en} when `issue` = id_valid & ~hazard & id_wb_en & (id_dest ≠ 0); otherwise EXE ← {0, 0, 0}.
- Match on entry e: e.v & (e.dest == src1 | (uses_src2 & e.dest == src2)). Register 0 never matches, because it is never entered.
- Hazard rule without forwarding: hazard = id_valid & (match EXE | match MEM | match WB). The register file is not write-through, so a WB match also stalls.
- hazard drives both `freeze` and `bubble`.
- Branch handling:
  - if_flush = id_valid & br_taken & ~hazard.
  - Hazard has priority: a branch whose operands are pending stalls first and flushes only in the cycle it proceeds.
- Counters:
  - stall_count += 1 each cycle freeze = 1.
  - flush_count += 1 each cycle if_flush = 1.
  - Both hold at 2^CNT_W − 1 once reached.
- id_valid = 0: freeze, bubble and if_flush are all 0, and nothing is issued.

## Timing
- freeze, bubble and if_flush are combinational from the ID inputs and the registered scoreboard. They are valid in the same cycle and take effect at the next edge.
- Scoreboard and counters update on the rising clk edge.
- Reset (async, effective immediately):
  - All scoreboard entries invalid and both counters 0.
  - While rst = 1, freeze, bubble and if_flush are forced to 0.
  - Reset mid-stall releases the stall at once. The first post-reset cycle sees an empty scoreboard.
- Maximum stall per hazard: 3 cycles without forwarding, 1 cycle with it.
- Stall cycles count every asserted cycle, not once per event.
- Simultaneous events:
  - A stalled ID instruction is not issued, so it cannot match itself.
  - A dependent pair that is back-to-back in both sources stalls for the longest pending match.

## Configuration
- Macro: FORWARDING_EN.
- Defined:
  - The EXE/MEM/WB forwarding unit exists in the datapath.
  - hazard = id_valid & match EXE & EXE.ld (load-use only, 1 bubble).
  - MEM and WB matches are ignored.
- Undefined:
  - Full interlock as described in Operation.
  - The `ld` field is still stored but unused.

## Test plan
- No forwarding, ALU dependency: the ID instruction in cycle 0 writes R3; in cycle 1 the ID instruction reads src1 = R3. Required: freeze = bubble = 1 in cycles 1–3, 0 in cycle 4, stall_count = 3. With FORWARDING_EN: no stall, stall_count = 0.
- FORWARDING_EN, load-use: a load writes R5, followed by an instruction with uses_src2 = 1 and src2 = R5. Required: exactly 1 stall cycle, then issue, stall_count = 1. With uses_src2 = 0: no stall.
- R0 destination: the ID instruction writes R0 with id_wb_en = 1, and the next instruction reads R0. Required: no stall in either build.
- Branch:
  - br_taken with clean operands: if_flush = 1 for one cycle, flush_count = 1.
  - A branch reading R7, issued right after an R7 write with no forwarding: if_flush = 0 for 3 cycles, then 1 in cycle 4.
- Reset mid-stall: assert rst in the 2nd stall cycle. Required: freeze drops immediately, counters read 0, and a repeat of the same src after rst deasserts issues with no stall.
- Saturation: CNT_W = 4 and continuous hazards. Required: stall_count sticks at 15.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: RAW interlock beside the ID stage of the 5-stage core.
// A 3-entry scoreboard (EXE/MEM/WB) records destinations in flight. ID is
// frozen and a bubble is injected on a hazard. The IF flush of a taken branch
// is gated by that hazard. Saturating stall/flush counters support debug.
// Optional build macro FORWARDING_EN: only load-use hazards against EXE stall.
module hazard_scheduler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             uses_src2,
  input  logic [4:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             br_taken,
  output logic             freeze,
  output logic             bubble,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       ld;
  } sb_entry_t;

  sb_entry_t        r_exe, r_mem, r_wb;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_m_exe, w_m_mem, w_m_wb;
  logic w_hazard, w_issue, w_flush;
  logic w_unused_ld;

  function automatic logic f_match(input sb_entry_t e, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic u2);
    return e.v & ((e.dest == s1) | (u2 & (e.dest == s2)));
  endfunction

  // Hazard detection, issue qualification and gated outputs.
  always_comb begin
    w_m_exe  = f_match(r_exe, src1, src2, uses_src2);
    w_m_mem  = f_match(r_mem, src1, src2, uses_src2);
    w_m_wb   = f_match(r_wb,  src1, src2, uses_src2);
`ifdef FORWARDING_EN
    w_hazard = id_valid & w_m_exe & r_exe.ld;
`else
    w_hazard = id_valid & (w_m_exe | w_m_mem | w_m_wb);
`endif
    w_issue  = id_valid & ~w_hazard & id_wb_en & (id_dest != 5'd0);
    w_flush  = id_valid & br_taken & ~w_hazard;
    freeze   = ~rst & w_hazard;
    bubble   = ~rst & w_hazard;
    if_flush = ~rst & w_flush;
  end

  // Load flags in MEM/WB (and EXE without forwarding) are carried but never read.
  assign w_unused_ld = ^{r_exe.ld, r_mem.ld, r_wb.ld};

  // Scoreboard shift: the back end never stalls, so entries advance every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= w_issue ? {1'b1, id_dest, id_mem_r_en} : '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (freeze && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (if_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed test-plan scenarios plus
// randomized traffic against a register-age reference model. A second
// instance with CNT_W = 4 exercises counter saturation.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, uses_src2 = 1'b0, id_wb_en = 1'b0;
  logic id_mem_r_en = 1'b0, br_taken = 1'b0;
  logic [4:0] src1 = '0, src2 = '0, id_dest = '0;

  logic freeze, bubble, if_flush;
  logic [15:0] stall_count, flush_count;
  logic s_freeze, s_bubble, s_if_flush;
  logic [3:0] s_stall, s_flush;

  hazard_scheduler u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .uses_src2(uses_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .freeze(freeze),
    .bubble(bubble), .if_flush(if_flush), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  hazard_scheduler #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .uses_src2(uses_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .freeze(s_freeze),
    .bubble(s_bubble), .if_flush(s_if_flush), .stall_count(s_stall),
    .flush_count(s_flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: for each register, the cycle in which its latest writer
  // left ID. A reader stalls while that writer is 1..3 cycles old (no
  // forwarding), or only when it is 1 cycle old and a load (forwarding).
  int cyc = 0;
  int last_cyc[32];
  bit last_ld[32];
  int m_stall = 0;
  int m_flush = 0;
  logic last_if_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    int age;
    age = cyc - last_cyc[r];
`ifdef FORWARDING_EN
    return (age == 1) && last_ld[r];
`else
    return (age >= 1) && (age <= 3);
`endif
  endfunction

  function automatic bit m_hazard();
    if (!id_valid) return 1'b0;
    return pending(src1) || (uses_src2 && pending(src2));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      last_cyc[i] = -1000;
      last_ld[i]  = 1'b0;
    end
    m_stall = 0;
    m_flush = 0;
  endtask

  // One ID cycle: drive, check combinational outputs mid-cycle, then counters after the edge.
  task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic [4:0] d, input logic we,
                      input logic ld, input logic br);
    bit h, fl;
    id_valid = v; src1 = s1; src2 = s2; uses_src2 = u2;
    id_dest = d; id_wb_en = we; id_mem_r_en = ld; br_taken = br;
    @(negedge clk);
    h  = m_hazard();
    fl = v & br & ~h;
    check("freeze", freeze, h);
    check("bubble", bubble, h);
    check("if_flush", if_flush, fl);
    check("sat_freeze", s_freeze, h);
    last_if_flush = if_flush;
    @(posedge clk);
    if (v && !h && we && (d != 5'd0)) begin
      last_cyc[d] = cyc;
      last_ld[d]  = ld;
    end
    cyc++;
    if (h)  m_stall++;
    if (fl) m_flush++;
    #1;
    check("stall_count", stall_count, sat(m_stall, 16));
    check("flush_count", flush_count, sat(m_flush, 16));
    check("sat_stall_count", s_stall, sat(m_stall, 4));
    check("sat_flush_count", s_flush, sat(m_flush, 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_freeze", freeze, 0);
    check("rst_bubble", bubble, 0);
    check("rst_if_flush", if_flush, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_flush_count", flush_count, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] flv;
    logic [3:0] flv_exp;
    model_clear();
    do_reset();

    // ALU dependency on R3.
    step(1, 0, 0, 0, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
    check("alu_dep_stalls", stall_count, 0);
`else
    check("alu_dep_stalls", stall_count, 3);
`endif

    // Load-use on src2 (R5), then the same with uses_src2 = 0.
    do_reset();
    step(1, 0, 0, 0, 5, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 5, 1, 0, 0, 0, 0);
`ifdef FORWARDING_EN
    check("load_use_stalls", stall_count, 1);
`else
    check("load_use_stalls", stall_count, 3);
`endif
    do_reset();
    step(1, 0, 0, 0, 5, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 5, 0, 0, 0, 0, 0);
    check("no_src2_stalls", stall_count, 0);

    // R0 destination never stalls.
    do_reset();
    step(1, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    check("r0_stalls", stall_count, 0);

    // Clean taken branch.
    do_reset();
    step(1, 1, 2, 1, 0, 0, 0, 1);
    check("br_clean_flush", last_if_flush, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("br_clean_count", flush_count, 1);

    // Branch reading R7 right after an R7 write.
    do_reset();
    step(1, 0, 0, 0, 7, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 7, 0, 1, 0, 0, 0, 1);
      flv[i] = last_if_flush;
    end
`ifdef FORWARDING_EN
    flv_exp = 4'b1111;
`else
    flv_exp = 4'b1000;
`endif
    check("br_r7_seq", flv, flv_exp);

    // Reset in the second cycle of a stall.
    do_reset();
    step(1, 0, 0, 0, 3, 1, 1, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midstall_freeze_pre", freeze, m_hazard());
    #1;
    rst = 1'b1;
    #1;
    check("midstall_freeze", freeze, 0);
    check("midstall_bubble", bubble, 0);
    check("midstall_stall_count", stall_count, 0);
    check("midstall_flush_count", flush_count, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check("post_rst_no_stall", stall_count, 0);

    // Continuous hazards saturate the 4-bit counter.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0, 0, 5, 1, 1, 0);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0, 0, 0);
    end
    check("sat_stall_sticks", s_stall, 15);
`ifdef FORWARDING_EN
    check("wide_stall_total", stall_count, 30);
`else
    check("wide_stall_total", stall_count, 60);
`endif

    // Randomized traffic on a small register set to provoke overlaps.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
